// File: rtl/alu_multicycle.sv
// Multi-cycle ALU with a ready/valid handshake and single-cycle logic/arith/shift ops.
// Defining ALU_MULDIV_EN adds iterative multiply/divide ops that resolve one bit per cycle.
module alu_multicycle #(
    parameter int DATA_WIDTH    = 32,
    parameter int OPCODE_LENGTH = 5
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [DATA_WIDTH-1:0]    SrcA,
    input  logic [DATA_WIDTH-1:0]    SrcB,
    input  logic [OPCODE_LENGTH-1:0] Operation,
    input  logic                     flush,
    output logic [DATA_WIDTH-1:0]    ALUResult,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic                     busy
);

    localparam int SHAMT_W = $clog2(DATA_WIDTH);
    localparam int CNT_W   = $clog2(DATA_WIDTH);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] ITER = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(DATA_WIDTH - 1);

    localparam logic [OPCODE_LENGTH-1:0] OP_AND  = OPCODE_LENGTH'('h00);
    localparam logic [OPCODE_LENGTH-1:0] OP_XOR  = OPCODE_LENGTH'('h01);
    localparam logic [OPCODE_LENGTH-1:0] OP_ADD  = OPCODE_LENGTH'('h02);
    localparam logic [OPCODE_LENGTH-1:0] OP_SLT  = OPCODE_LENGTH'('h03);
    localparam logic [OPCODE_LENGTH-1:0] OP_OR   = OPCODE_LENGTH'('h05);
    localparam logic [OPCODE_LENGTH-1:0] OP_SLL  = OPCODE_LENGTH'('h06);
    localparam logic [OPCODE_LENGTH-1:0] OP_SRA  = OPCODE_LENGTH'('h07);
    localparam logic [OPCODE_LENGTH-1:0] OP_EQ   = OPCODE_LENGTH'('h08);
    localparam logic [OPCODE_LENGTH-1:0] OP_SUB  = OPCODE_LENGTH'('h0A);
    localparam logic [OPCODE_LENGTH-1:0] OP_SLTU = OPCODE_LENGTH'('h0C);
    localparam logic [OPCODE_LENGTH-1:0] OP_SRL  = OPCODE_LENGTH'('h0E);

    logic [1:0]            state_q, state_d;
    logic [DATA_WIDTH-1:0] result_q, result_d;
    logic                  out_valid_q, out_valid_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;

    logic [SHAMT_W-1:0]    shamt;
    logic [DATA_WIDTH-1:0] simple_result;
    logic [DATA_WIDTH-1:0] iter_result;
    logic                  is_iter_op;
    logic                  accept;

    // Flush blocks acceptance so an abandoned cycle never starts new work.
    assign accept    = in_valid && (state_q == IDLE) && !flush;
    assign in_ready  = (state_q == IDLE);
    assign out_valid = out_valid_q;
    assign ALUResult = result_q;

    always_comb begin
        shamt         = SrcB[SHAMT_W-1:0];
        simple_result = '0;
        case (Operation)
            OP_AND:  simple_result = SrcA & SrcB;
            OP_XOR:  simple_result = SrcA ^ SrcB;
            OP_ADD:  simple_result = SrcA + SrcB;
            OP_SLT:  simple_result = {{(DATA_WIDTH-1){1'b0}}, ($signed(SrcA) < $signed(SrcB))};
            OP_OR:   simple_result = SrcA | SrcB;
            OP_SLL:  simple_result = SrcA << shamt;
            OP_SRA:  simple_result = $unsigned($signed(SrcA) >>> shamt);
            OP_EQ:   simple_result = {{(DATA_WIDTH-1){1'b0}}, (SrcA == SrcB)};
            OP_SUB:  simple_result = SrcA - SrcB;
            OP_SLTU: simple_result = {{(DATA_WIDTH-1){1'b0}}, (SrcA < SrcB)};
            OP_SRL:  simple_result = SrcA >> shamt;
            default: simple_result = '0;
        endcase
    end

`ifdef ALU_MULDIV_EN
    localparam logic [OPCODE_LENGTH-1:0] OP_MUL   = OPCODE_LENGTH'('h10);
    localparam logic [OPCODE_LENGTH-1:0] OP_MULH  = OPCODE_LENGTH'('h11);
    localparam logic [OPCODE_LENGTH-1:0] OP_MULHU = OPCODE_LENGTH'('h12);
    localparam logic [OPCODE_LENGTH-1:0] OP_DIV   = OPCODE_LENGTH'('h14);
    localparam logic [OPCODE_LENGTH-1:0] OP_DIVU  = OPCODE_LENGTH'('h15);
    localparam logic [OPCODE_LENGTH-1:0] OP_REM   = OPCODE_LENGTH'('h16);
    localparam logic [OPCODE_LENGTH-1:0] OP_REMU  = OPCODE_LENGTH'('h17);

    logic [DATA_WIDTH-1:0]    a_q, a_d;
    logic [DATA_WIDTH-1:0]    hi_q, hi_d;
    logic [DATA_WIDTH-1:0]    lo_q, lo_d;
    logic [DATA_WIDTH-1:0]    m_q, m_d;
    logic [OPCODE_LENGTH-1:0] op_q, op_d;
    logic                     neg_q, neg_d;
    logic                     rneg_q, rneg_d;

    logic                     src_signed;
    logic                     a_neg;
    logic                     b_neg;
    logic                     is_div_op;
    logic                     q_bit;
    logic [DATA_WIDTH:0]      add_sum;
    logic [DATA_WIDTH:0]      shifted;
    logic [DATA_WIDTH:0]      diff;
    logic [DATA_WIDTH-1:0]    mulh_neg_hi;

    always_comb begin
        is_iter_op = (Operation == OP_MUL)  || (Operation == OP_MULH) ||
                     (Operation == OP_MULHU) || (Operation == OP_DIV) ||
                     (Operation == OP_DIVU) || (Operation == OP_REM) ||
                     (Operation == OP_REMU);
        src_signed = (Operation == OP_MULH) || (Operation == OP_DIV) || (Operation == OP_REM);
        a_neg      = src_signed && SrcA[DATA_WIDTH-1];
        b_neg      = src_signed && SrcB[DATA_WIDTH-1];
    end

    // Signed ops run on magnitudes; hi/lo hold {product} or {remainder, quotient}.
    always_comb begin
        a_d       = a_q;
        hi_d      = hi_q;
        lo_d      = lo_q;
        m_d       = m_q;
        op_d      = op_q;
        neg_d     = neg_q;
        rneg_d    = rneg_q;
        is_div_op = (op_q == OP_DIV) || (op_q == OP_DIVU) ||
                    (op_q == OP_REM) || (op_q == OP_REMU);
        add_sum   = {1'b0, hi_q} + (lo_q[0] ? {1'b0, m_q} : '0);
        shifted   = {hi_q, lo_q[DATA_WIDTH-1]};
        diff      = shifted - {1'b0, m_q};
        q_bit     = !diff[DATA_WIDTH];
        if (accept && is_iter_op) begin
            a_d    = SrcA;
            op_d   = Operation;
            hi_d   = '0;
            lo_d   = a_neg ? -SrcA : SrcA;
            m_d    = b_neg ? -SrcB : SrcB;
            neg_d  = a_neg ^ b_neg;
            rneg_d = a_neg;
        end else if (state_q == ITER) begin
            if (is_div_op) begin
                hi_d = q_bit ? diff[DATA_WIDTH-1:0] : shifted[DATA_WIDTH-1:0];
                lo_d = {lo_q[DATA_WIDTH-2:0], q_bit};
            end else begin
                hi_d = add_sum[DATA_WIDTH:1];
                lo_d = {add_sum[0], lo_q[DATA_WIDTH-1:1]};
            end
        end
    end

    // Upper half of -{hi,lo}: the +1 only carries into hi when lo is zero.
    always_comb begin
        mulh_neg_hi = ~hi_d + {{(DATA_WIDTH-1){1'b0}}, (lo_d == '0)};
        iter_result = '0;
        case (op_q)
            OP_MUL:          iter_result = lo_d;
            OP_MULH:         iter_result = neg_q ? mulh_neg_hi : hi_d;
            OP_MULHU:        iter_result = hi_d;
            OP_DIV, OP_DIVU: iter_result = (m_q == '0) ? '1 : (neg_q ? -lo_d : lo_d);
            OP_REM, OP_REMU: iter_result = (m_q == '0) ? a_q : (rneg_q ? -hi_d : hi_d);
            default:         iter_result = '0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_q    <= '0;
            hi_q   <= '0;
            lo_q   <= '0;
            m_q    <= '0;
            op_q   <= '0;
            neg_q  <= 1'b0;
            rneg_q <= 1'b0;
        end else begin
            a_q    <= a_d;
            hi_q   <= hi_d;
            lo_q   <= lo_d;
            m_q    <= m_d;
            op_q   <= op_d;
            neg_q  <= neg_d;
            rneg_q <= rneg_d;
        end
    end

    assign busy = (state_q == ITER);
`else
    assign is_iter_op  = 1'b0;
    assign iter_result = '0;
    assign busy        = 1'b0;
`endif

    always_comb begin
        state_d     = state_q;
        result_d    = result_q;
        out_valid_d = out_valid_q;
        cnt_d       = cnt_q;
        if (flush) begin
            state_d     = IDLE;
            out_valid_d = 1'b0;
            cnt_d       = '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (accept) begin
                        if (is_iter_op) begin
                            state_d = ITER;
                            cnt_d   = '0;
                        end else begin
                            state_d     = DONE;
                            result_d    = simple_result;
                            out_valid_d = 1'b1;
                        end
                    end
                end
                ITER: begin
                    if (cnt_q == LAST_ITER) begin
                        state_d     = DONE;
                        result_d    = iter_result;
                        out_valid_d = 1'b1;
                        cnt_d       = '0;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        state_d     = IDLE;
                        out_valid_d = 1'b0;
                    end
                end
                default: begin
                    state_d     = IDLE;
                    out_valid_d = 1'b0;
                    cnt_d       = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            result_q    <= '0;
            out_valid_q <= 1'b0;
            cnt_q       <= '0;
        end else begin
            state_q     <= state_d;
            result_q    <= result_d;
            out_valid_q <= out_valid_d;
            cnt_q       <= cnt_d;
        end
    end

endmodule

// File: tb/tb_alu_multicycle.sv
// Self-checking bench for alu_multicycle: directed corner cases plus randomized ops checked
// against an arithmetic reference model; mul/div checks compile in under ALU_MULDIV_EN.
module tb_alu_multicycle;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] SrcA;
    logic [31:0] SrcB;
    logic [4:0]  Operation;
    logic        flush;
    logic [31:0] ALUResult;
    logic        out_valid;
    logic        out_ready;
    logic        busy;

    int passCount  = 0;
    int checkCount = 0;

    alu_multicycle #(.DATA_WIDTH(32), .OPCODE_LENGTH(5)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .SrcA      (SrcA),
        .SrcB      (SrcB),
        .Operation (Operation),
        .flush     (flush),
        .ALUResult (ALUResult),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .busy      (busy)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: simulation did not finish, observed timeout required finish");
        $fatal(1, "[TB] watchdog expired");
    end

    function automatic bit isIter(input logic [4:0] op);
`ifdef ALU_MULDIV_EN
        return op inside {5'h10, 5'h11, 5'h12, 5'h14, 5'h15, 5'h16, 5'h17};
`else
        return (op == 5'h1F) && (op != 5'h1F);
`endif
    endfunction

    // Arithmetic reference: operations evaluated directly on integer values.
    function automatic logic [31:0] refModel(input logic [4:0] op, input logic [31:0] a,
                                             input logic [31:0] b);
        int          sa;
        int          sb;
        int unsigned sh;
        longint      sprod;
        logic [63:0] uprod;
        sa = a;
        sb = b;
        sh = b % 32;
        sprod = 0;
        uprod = 0;
        case (op)
            5'h00: return a & b;
            5'h01: return a ^ b;
            5'h02: return a + b;
            5'h03: return (sa < sb) ? 32'd1 : 32'd0;
            5'h05: return a | b;
            5'h06: return a << sh;
            5'h07: return 32'(sa >>> sh);
            5'h08: return (a == b) ? 32'd1 : 32'd0;
            5'h0A: return a - b;
            5'h0C: return (a < b) ? 32'd1 : 32'd0;
            5'h0E: return a >> sh;
`ifdef ALU_MULDIV_EN
            5'h10: return a * b;
            5'h11: begin
                sprod = longint'(sa) * longint'(sb);
                return sprod[63:32];
            end
            5'h12: begin
                uprod = {32'd0, a} * {32'd0, b};
                return uprod[63:32];
            end
            5'h14: begin
                if (b == 32'd0) return 32'hFFFFFFFF;
                if (a == 32'h80000000 && b == 32'hFFFFFFFF) return a;
                return 32'(sa / sb);
            end
            5'h15: return (b == 32'd0) ? 32'hFFFFFFFF : a / b;
            5'h16: begin
                if (b == 32'd0) return a;
                if (a == 32'h80000000 && b == 32'hFFFFFFFF) return 32'd0;
                return 32'(sa % sb);
            end
            5'h17: return (b == 32'd0) ? a : a % b;
`endif
            default: return 32'd0;
        endcase
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checkCount++;
        assert (observed === expected) begin
            passCount++;
        end else begin
            $display("[TB] FAIL %s: observed=0x%0h expected=0x%0h", tag, observed, expected);
            $error("[TB] %s observed 0x%0h expected 0x%0h", tag, observed, expected);
        end
    endtask

    // One full transaction with out_ready high; checks result, latency, busy time, handshake.
    task automatic applyStimulus(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b,
                                 input string tag, output logic [31:0] got);
        int          lat;
        int          busyCycles;
        logic [31:0] expected;
        expected = refModel(op, a, b);
        @(negedge clk);
        in_valid  = 1'b1;
        Operation = op;
        SrcA      = a;
        SrcB      = b;
        out_ready = 1'b1;
        flush     = 1'b0;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        SrcA     = $urandom;
        SrcB     = $urandom;
        lat        = 1;
        busyCycles = 0;
        while (!out_valid && lat < 100) begin
            if (busy) busyCycles++;
            @(posedge clk);
            #1;
            lat++;
        end
        got = ALUResult;
        checkOutput({tag, " result"}, ALUResult, expected);
        checkOutput({tag, " latency"}, lat, isIter(op) ? 33 : 1);
        checkOutput({tag, " busy cycles"}, busyCycles, isIter(op) ? 32 : 0);
        @(posedge clk);
        #1;
        checkOutput({tag, " handshake out_valid"}, out_valid, 1'b0);
    endtask

    initial begin
        logic [31:0] got;
        logic [4:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        bit          sawValid;

        rst_n     = 1'b1;
        in_valid  = 1'b0;
        SrcA      = '0;
        SrcB      = '0;
        Operation = '0;
        flush     = 1'b0;
        out_ready = 1'b1;

        // Asynchronous reset before any clock edge.
        #2 rst_n = 1'b0;
        #1;
        checkOutput("reset ALUResult", ALUResult, 32'd0);
        checkOutput("reset out_valid", out_valid, 1'b0);
        checkOutput("reset busy", busy, 1'b0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        checkOutput("post-reset in_ready", in_ready, 1'b1);

        applyStimulus(5'h02, 32'hFFFFFFFF, 32'd1, "add wrap", got);
        checkOutput("add wrap literal", got, 32'h00000000);
        applyStimulus(5'h07, 32'h80000000, 32'h21, "sra shamt", got);
        checkOutput("sra literal", got, 32'hC0000000);
        applyStimulus(5'h08, 32'h1234ABCD, 32'h1234ABCD, "equal same", got);
        applyStimulus(5'h03, 32'hFFFFFFF0, 32'd5, "slt neg", got);
        applyStimulus(5'h0C, 32'hFFFFFFF0, 32'd5, "sltu big", got);
        applyStimulus(5'h04, 32'hDEADBEEF, 32'h1, "undef 04", got);
        applyStimulus(5'h1B, 32'hDEADBEEF, 32'h3, "undef 1B", got);

        for (int i = 0; i < 32; i++) begin
            applyStimulus(5'(i), $urandom, $urandom, $sformatf("sweep op%0d", i), got);
        end

        for (int i = 0; i < 40; i++) begin
            op = 5'($urandom_range(0, 31));
            a  = $urandom;
            b  = (i % 8 == 0) ? 32'd0 : ((i % 4 == 1) ? 32'($urandom_range(1, 40)) : $urandom);
            applyStimulus(op, a, b, $sformatf("rand%0d op%0d", i, op), got);
        end

`ifdef ALU_MULDIV_EN
        applyStimulus(5'h11, 32'hFFFFFFFE, 32'd3, "mulh", got);
        checkOutput("mulh literal", got, 32'hFFFFFFFF);
        applyStimulus(5'h10, 32'hFFFFFFFE, 32'd3, "mul", got);
        checkOutput("mul literal", got, 32'hFFFFFFFA);
        applyStimulus(5'h14, 32'h80000000, 32'hFFFFFFFF, "div overflow", got);
        checkOutput("div overflow literal", got, 32'h80000000);
        applyStimulus(5'h15, 32'd7, 32'd0, "divu zero", got);
        checkOutput("divu zero literal", got, 32'hFFFFFFFF);
        applyStimulus(5'h16, 32'hFFFFFFF9, 32'd2, "rem neg", got);
        checkOutput("rem neg literal", got, 32'hFFFFFFFF);
`endif

        // Back-pressure: result held, competing request ignored until the handshake.
        @(negedge clk);
        in_valid  = 1'b1;
        Operation = 5'h02;
        SrcA      = 32'd2;
        SrcB      = 32'd3;
        out_ready = 1'b0;
        @(posedge clk);
        #1;
        Operation = 5'h0A;
        SrcA      = 32'd100;
        SrcB      = 32'd1;
        checkOutput("bp first out_valid", out_valid, 1'b1);
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            #1;
            checkOutput($sformatf("bp hold%0d out_valid", i), out_valid, 1'b1);
            checkOutput($sformatf("bp hold%0d result", i), ALUResult, 32'd5);
            checkOutput($sformatf("bp hold%0d in_ready", i), in_ready, 1'b0);
        end
        @(negedge clk);
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        checkOutput("bp release out_valid", out_valid, 1'b0);
        checkOutput("bp release in_ready", in_ready, 1'b1);
        checkOutput("bp release result", ALUResult, 32'd5);

        // Flush in DONE discards the result but leaves ALUResult untouched.
        @(negedge clk);
        in_valid  = 1'b1;
        Operation = 5'h02;
        SrcA      = 32'd7;
        SrcB      = 32'd8;
        out_ready = 1'b0;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        checkOutput("flush-done pre out_valid", out_valid, 1'b1);
        @(negedge clk);
        flush = 1'b1;
        @(posedge clk);
        #1;
        flush = 1'b0;
        checkOutput("flush-done out_valid", out_valid, 1'b0);
        checkOutput("flush-done in_ready", in_ready, 1'b1);
        checkOutput("flush-done result kept", ALUResult, 32'd15);

        // Flush beats a simultaneous request in IDLE.
        @(negedge clk);
        flush     = 1'b1;
        in_valid  = 1'b1;
        Operation = 5'h02;
        SrcA      = 32'd1;
        SrcB      = 32'd1;
        @(posedge clk);
        #1;
        flush    = 1'b0;
        in_valid = 1'b0;
        checkOutput("flush-accept in_ready", in_ready, 1'b1);
        checkOutput("flush-accept out_valid", out_valid, 1'b0);
        checkOutput("flush-accept result kept", ALUResult, 32'd15);
        out_ready = 1'b1;
        applyStimulus(5'h02, 32'd2, 32'd3, "after flush add", got);
        checkOutput("after flush add literal", got, 32'd5);

`ifdef ALU_MULDIV_EN
        // Flush partway through a DIVU.
        @(negedge clk);
        in_valid  = 1'b1;
        Operation = 5'h15;
        SrcA      = 32'd1000;
        SrcB      = 32'd7;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (9) @(posedge clk);
        @(negedge clk);
        flush = 1'b1;
        @(posedge clk);
        #1;
        flush = 1'b0;
        checkOutput("flush-divu busy", busy, 1'b0);
        checkOutput("flush-divu in_ready", in_ready, 1'b1);
        checkOutput("flush-divu out_valid", out_valid, 1'b0);
        sawValid = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk);
            #1;
            if (out_valid) sawValid = 1'b1;
        end
        checkOutput("flush-divu no late valid", sawValid, 1'b0);
        applyStimulus(5'h02, 32'd2, 32'd3, "after divu flush add", got);
        checkOutput("after divu flush literal", got, 32'd5);

        // Reset pulse in the middle of a MUL.
        @(negedge clk);
        in_valid  = 1'b1;
        Operation = 5'h10;
        SrcA      = 32'h12345;
        SrcB      = 32'h777;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (10) @(posedge clk);
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        checkOutput("rst-mul busy", busy, 1'b0);
        checkOutput("rst-mul out_valid", out_valid, 1'b0);
        checkOutput("rst-mul ALUResult", ALUResult, 32'd0);
        checkOutput("rst-mul in_ready", in_ready, 1'b1);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        checkOutput("rst-mul release in_ready", in_ready, 1'b1);
        applyStimulus(5'h10, 32'h12345, 32'h777, "mul after reset", got);
`endif

        // Reset pulse while a result is parked in DONE.
        @(negedge clk);
        in_valid  = 1'b1;
        Operation = 5'h01;
        SrcA      = 32'hF0F0F0F0;
        SrcB      = 32'h0FF00FF0;
        out_ready = 1'b0;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        checkOutput("rst-done pre result", ALUResult, 32'hFF00FF00);
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        checkOutput("rst-done out_valid", out_valid, 1'b0);
        checkOutput("rst-done ALUResult", ALUResult, 32'd0);
        checkOutput("rst-done in_ready", in_ready, 1'b1);
        @(negedge clk);
        rst_n     = 1'b1;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        checkOutput("rst-done release in_ready", in_ready, 1'b1);
        applyStimulus(5'h0E, 32'h80000000, 32'h3F, "srl after reset", got);
        checkOutput("srl after reset literal", got, 32'd1);

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
